// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer bus master: slave register map,
// control register bit layout, control words and FSM state encoding.
package timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;

    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    localparam logic [15:0] CTRL_STOP_VAL = 16'h0001 << CTRL_STOP_BIT;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR_ST,
        SNAP_W,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP,
        STOP_W
    } state_t;

    // Control word that starts the counter with the timeout interrupt enabled.
    function automatic logic [15:0] ctrl_run_val(input logic cont);
        logic [15:0] v;
        v = 16'h0000;
        v[CTRL_ITO_BIT]   = 1'b1;
        v[CTRL_START_BIT] = 1'b1;
        v[CTRL_CONT_BIT]  = cont;
        return v;
    endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs an interval timer slave, services its
// timeouts, takes counter snapshots and stops it on request.
module timer_ctrl_master
    import timer_pkg::*;
#(
    parameter int CONTINUOUS = 1,
    parameter int TICK_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       period,
    input  logic              snap_req,
    output logic              busy,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot,
    output logic              snap_valid,
    output logic [2:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [15:0]       writedata,
    input  logic [15:0]       readdata,
    input  logic              irq
);

    localparam logic [15:0] CTRL_RUN_VAL = ctrl_run_val(CONTINUOUS != 0);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] period_hi_reg;
    logic [15:0] snap_lo_reg;
    logic        stop_pend_reg;
    logic        snap_pend_reg;
    logic        irq_mask_reg;

    logic        cs_next;
    logic [2:0]  addr_next;
    logic [15:0] wd_next;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = WR_PL;
            WR_PL:    state_next = WR_PH;
            WR_PH:    state_next = WR_CTRL;
            WR_CTRL:  state_next = RUN;
            RUN: begin
                if (stop || stop_pend_reg)
                    state_next = STOP_W;
                else if (irq && !irq_mask_reg)
                    state_next = CLR_ST;
                else if (snap_req || snap_pend_reg)
                    state_next = SNAP_W;
            end
            CLR_ST:   state_next = (CONTINUOUS != 0) ? RUN : IDLE;
            SNAP_W:   state_next = SNAP_RL;
            SNAP_RL:  state_next = SNAP_RH;
            SNAP_RH:  state_next = SNAP_CAP;
            SNAP_CAP: state_next = RUN;
            STOP_W:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Bus signals are decoded from the next state so the registered outputs
    // line up with the state they belong to.
    always_comb begin
        cs_next   = 1'b0;
        addr_next = 3'd0;
        wd_next   = 16'h0000;
        case (state_next)
            WR_PL: begin
                cs_next   = 1'b1;
                addr_next = REG_PERIOD_L;
                wd_next   = period[15:0];
            end
            WR_PH: begin
                cs_next   = 1'b1;
                addr_next = REG_PERIOD_H;
                wd_next   = period_hi_reg;
            end
            WR_CTRL: begin
                cs_next   = 1'b1;
                addr_next = REG_CONTROL;
                wd_next   = CTRL_RUN_VAL;
            end
            CLR_ST: begin
                cs_next   = 1'b1;
                addr_next = REG_STATUS;
            end
            SNAP_W: begin
                cs_next   = 1'b1;
                addr_next = REG_SNAP_L;
            end
            SNAP_RL:  addr_next = REG_SNAP_L;
            SNAP_RH:  addr_next = REG_SNAP_H;
            STOP_W: begin
                cs_next   = 1'b1;
                addr_next = REG_CONTROL;
                wd_next   = CTRL_STOP_VAL;
            end
            default: begin
                cs_next   = 1'b0;
                addr_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            chipselect    <= 1'b0;
            write_n       <= 1'b1;
            address       <= 3'd0;
            writedata     <= 16'h0000;
            tick_count    <= '0;
            snapshot      <= 32'h0;
            snap_valid    <= 1'b0;
            period_hi_reg <= 16'h0000;
            snap_lo_reg   <= 16'h0000;
            stop_pend_reg <= 1'b0;
            snap_pend_reg <= 1'b0;
            irq_mask_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            busy       <= (state_next != IDLE);
            chipselect <= cs_next;
            write_n    <= ~cs_next;
            address    <= addr_next;
            writedata  <= wd_next;
            snap_valid <= 1'b0;

            // The slave drops irq on the edge that ends CLR_ST; its old level
            // is still visible for one more cycle.
            irq_mask_reg <= (state_reg == CLR_ST);

            if (state_reg == IDLE && start) begin
                period_hi_reg <= period[31:16];
                tick_count    <= '0;
            end
            if (state_reg == CLR_ST)
                tick_count <= tick_count + TICK_W'(1);

            if (state_reg == SNAP_RH)
                snap_lo_reg <= readdata;
            if (state_reg == SNAP_CAP) begin
                snapshot   <= {readdata, snap_lo_reg};
                snap_valid <= 1'b1;
            end

            if (state_next == IDLE)
                stop_pend_reg <= 1'b0;
            else if (stop && state_reg != IDLE && state_reg != RUN)
                stop_pend_reg <= 1'b1;

            if (state_reg == STOP_W)
                snap_pend_reg <= 1'b0;
            else if (state_reg == RUN && state_next == SNAP_W)
                snap_pend_reg <= 1'b0;
            else if (snap_req)
                snap_pend_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed bench for timer_ctrl_master: a periodic instance with a small timer
// slave model and a one-shot instance probed directly on its bus outputs.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset, start, stop, snap_req, irq, start_os, irq_os;
    logic [31:0] period;
    logic [15:0] readdata;

    logic        busy, snap_valid, chipselect, write_n;
    logic [15:0] tick_count, writedata;
    logic [31:0] snapshot;
    logic [2:0]  address;

    logic        busy_os, snap_valid_os, chipselect_os, write_n_os;
    logic [15:0] tick_count_os, writedata_os;
    logic [31:0] snapshot_os;
    logic [2:0]  address_os;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timer_ctrl_master #(.CONTINUOUS(1), .TICK_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .period(period),
        .snap_req(snap_req), .busy(busy), .tick_count(tick_count),
        .snapshot(snapshot), .snap_valid(snap_valid), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    timer_ctrl_master #(.CONTINUOUS(0), .TICK_W(16)) dut_os (
        .clk(clk), .reset(reset), .start(start_os), .stop(stop), .period(period),
        .snap_req(snap_req), .busy(busy_os), .tick_count(tick_count_os),
        .snapshot(snapshot_os), .snap_valid(snap_valid_os), .address(address_os),
        .chipselect(chipselect_os), .write_n(write_n_os), .writedata(writedata_os),
        .readdata(readdata), .irq(irq_os)
    );

    // Timer slave model: snap_l write latches the counter, reads are registered.
    logic [31:0] slave_counter = 32'h0;
    logic [31:0] snap_latch    = 32'h0;
    logic [31:0] wlog[$];
    int          wcyc[$];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (chipselect && !write_n) begin
            wlog.push_back({13'h0, address, writedata});
            wcyc.push_back(cyc);
            if (address == 3'd4)
                snap_latch <= slave_counter;
        end
        case (address)
            3'd4:    readdata <= snap_latch[15:0];
            3'd5:    readdata <= snap_latch[31:16];
            default: readdata <= 16'h0000;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < wcyc.size()) return wcyc[i];
        return -100;
    endfunction

    task automatic clear_log();
        wlog.delete();
        wcyc.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first_hi;
        int n_hi;

        reset = 1'b1; start = 1'b0; stop = 1'b0; snap_req = 1'b0;
        irq = 1'b0; start_os = 1'b0; irq_os = 1'b0; period = 32'h0;
        readdata = 16'h0;
        step(2);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_cs", 32'(chipselect), 32'h0);
        check_eq("rst_write_n", 32'(write_n), 32'h1);
        check_eq("rst_addr", 32'(address), 32'h0);
        check_eq("rst_wdata", 32'(writedata), 32'h0);
        check_eq("rst_tick", 32'(tick_count), 32'h0);
        check_eq("rst_snap", snapshot, 32'h0);
        check_eq("rst_snap_valid", 32'(snap_valid), 32'h0);
        reset = 1'b0;
        step(1);

        // Period programming
        clear_log();
        period = 32'h0001_387F;
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        check_eq("prog_nwr", 32'(wlog.size()), 32'd3);
        check_eq("prog_wr0", wr_at(0), 32'h0002_387F);
        check_eq("prog_wr1", wr_at(1), 32'h0003_0001);
        check_eq("prog_wr2", wr_at(2), 32'h0001_0007);
        check_eq("prog_span", 32'(cyc_at(2) - cyc_at(0)), 32'd2);
        check_eq("prog_busy", 32'(busy), 32'h1);

        // Three timeouts
        clear_log();
        for (int i = 0; i < 3; i++) begin
            irq = 1'b1; step(1); irq = 1'b0;
            step(3);
        end
        check_eq("tmo_nwr", 32'(wlog.size()), 32'd3);
        check_eq("tmo_wr0", wr_at(0), 32'h0000_0000);
        check_eq("tmo_wr2", wr_at(2), 32'h0000_0000);
        check_eq("tmo_tick", 32'(tick_count), 32'd3);

        // irq still high on the cycle after CLR_ST must not retrigger
        clear_log();
        irq = 1'b1; step(3); irq = 1'b0;
        step(2);
        check_eq("mask_nwr", 32'(wlog.size()), 32'd1);
        check_eq("mask_tick", 32'(tick_count), 32'd4);

        // Snapshot
        clear_log();
        slave_counter = 32'h0001_2345;
        snap_req = 1'b1; step(1); snap_req = 1'b0;
        first_hi = -1;
        n_hi = 0;
        for (int i = 0; i < 7; i++) begin
            if (snap_valid) begin
                if (first_hi < 0) first_hi = i;
                n_hi++;
            end
            step(1);
        end
        check_eq("snap_wr", wr_at(0), 32'h0004_0000);
        check_eq("snap_nwr", 32'(wlog.size()), 32'd1);
        check_eq("snap_latency", 32'(first_hi), 32'd4);
        check_eq("snap_pulses", 32'(n_hi), 32'd1);
        check_eq("snap_value", snapshot, 32'h0001_2345);

        // Stop from RUN, then a stop in IDLE that must be ignored
        clear_log();
        stop = 1'b1; step(1); stop = 1'b0;
        step(2);
        check_eq("stop_wr", wr_at(0), 32'h0001_0008);
        check_eq("stop_busy", 32'(busy), 32'h0);
        clear_log();
        stop = 1'b1; step(1); stop = 1'b0;
        step(2);
        check_eq("idle_stop_nwr", 32'(wlog.size()), 32'd0);

        // Restart clears tick_count; simultaneous irq + snap_req
        clear_log();
        period = 32'h0000_0100;
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        check_eq("restart_nwr", 32'(wlog.size()), 32'd3);
        check_eq("restart_tick", 32'(tick_count), 32'd0);
        clear_log();
        slave_counter = 32'h0ABC_DEF0;
        irq = 1'b1; snap_req = 1'b1; step(1); irq = 1'b0; snap_req = 1'b0;
        step(8);
        check_eq("both_wr0", wr_at(0), 32'h0000_0000);
        check_eq("both_wr1", wr_at(1), 32'h0004_0000);
        check_eq("both_tick", 32'(tick_count), 32'd1);
        check_eq("both_snap", snapshot, 32'h0ABC_DEF0);

        // Stop during WR_PH is deferred to the first RUN cycle
        stop = 1'b1; step(1); stop = 1'b0;
        step(2);
        clear_log();
        period = 32'h0002_0003;
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        stop = 1'b1; step(1); stop = 1'b0;
        step(4);
        check_eq("pstop_nwr", 32'(wlog.size()), 32'd4);
        check_eq("pstop_ctrl", wr_at(2), 32'h0001_0007);
        check_eq("pstop_stop", wr_at(3), 32'h0001_0008);
        check_eq("pstop_gap", 32'(cyc_at(3) - cyc_at(2)), 32'd2);
        check_eq("pstop_busy", 32'(busy), 32'h0);

        // Reset during WR_PL abandons the sequence
        clear_log();
        start = 1'b1; step(1); start = 1'b0;
        reset = 1'b1; step(1); reset = 1'b0;
        step(5);
        check_eq("rmid_nwr", 32'(wlog.size()), 32'd1);
        check_eq("rmid_wr0", wr_at(0), 32'h0002_0003);
        check_eq("rmid_busy", 32'(busy), 32'h0);
        check_eq("rmid_cs", 32'(chipselect), 32'h0);
        check_eq("rmid_write_n", 32'(write_n), 32'h1);
        check_eq("rmid_addr", 32'(address), 32'h0);
        check_eq("rmid_wdata", 32'(writedata), 32'h0);
        check_eq("rmid_snap", snapshot, 32'h0);

        // One-shot instance
        period = 32'h0000_0050;
        start_os = 1'b1; step(1); start_os = 1'b0;
        check_eq("os_pl_addr", 32'(address_os), 32'd2);
        check_eq("os_pl_data", 32'(writedata_os), 32'h0050);
        step(2);
        check_eq("os_ctrl_addr", 32'(address_os), 32'd1);
        check_eq("os_ctrl_data", 32'(writedata_os), 32'h0005);
        check_eq("os_ctrl_wr", 32'({chipselect_os, write_n_os}), 32'h2);
        step(1);
        check_eq("os_run_busy", 32'(busy_os), 32'h1);
        irq_os = 1'b1; step(1); irq_os = 1'b0;
        check_eq("os_clr", 32'({chipselect_os, write_n_os, address_os}), 32'h10);
        step(1);
        check_eq("os_done_busy", 32'(busy_os), 32'h0);
        check_eq("os_done_tick", 32'(tick_count_os), 32'd1);
        check_eq("os_done_cs", 32'(chipselect_os), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
